// File: rtl/i2s_receiver.sv
// I2S receive deserializer: synchronizes the serial bit clock, word select and
// data into the clk domain, reassembles MSB-first words per channel and
// presents each completed word with a one-cycle valid strobe.
`timescale 1ns/1ps

module i2s_receiver #(
    parameter int unsigned NUM_BITS = 24,
    parameter int unsigned NUM_CHAN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_clk,
    input  logic                word_select,
    input  logic                serial_data,
    output logic [NUM_BITS-1:0] sample_data,
    output logic                sample_chan,
    output logic                sample_valid,
    output logic                frame_err,
    output logic                locked
);

    localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Reset synchronizer outputs
    logic rst_meta;
    logic rst_n_sync;

    // Input synchronizers and bit-clock edge detect
    logic sclk_meta;
    logic sclk_sync;
    logic sclk_prev;
    logic ws_meta;
    logic ws_sync;
    logic sd_meta;
    logic sd_sync;
    logic s_clk_pos;

    // Word-select history, one sample per bit-clock rising edge
    logic ws_last_q;
    logic ws_last_d;
    logic ws_primed_q;
    logic ws_primed_d;
    logic ws_trans;

    // Framing state and datapath
    state_t                state_q;
    state_t                state_d;
    logic [NUM_BITS-1:0]   shift_q;
    logic [NUM_BITS-1:0]   shift_d;
    logic [NUM_BITS-1:0]   shift_nxt;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [CNT_W-1:0]      count_inc;
    logic                  chan_q;
    logic                  chan_d;
    logic [NUM_CHAN-1:0]   good_q;
    logic [NUM_CHAN-1:0]   good_d;

    // Next values for the registered outputs
    logic [NUM_BITS-1:0]   sample_data_d;
    logic                  sample_chan_d;
    logic                  sample_valid_d;
    logic                  frame_err_d;
    logic                  locked_d;

    // Reset asserts immediately and releases two clk edges after rst rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    // Two-flop synchronizers; sclk_prev feeds the rising-edge detector
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            ws_meta   <= 1'b0;
            ws_sync   <= 1'b0;
            sd_meta   <= 1'b0;
            sd_sync   <= 1'b0;
        end else begin
            sclk_meta <= s_clk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ws_meta   <= word_select;
            ws_sync   <= ws_meta;
            sd_meta   <= serial_data;
            sd_sync   <= sd_meta;
        end
    end

    // One-clk strobe per bit-clock rising edge; WS/SD share the same sync depth
    assign s_clk_pos = sclk_sync & ~sclk_prev;

    // A transition needs a prior sample, so the first edge after reset only primes
    assign ws_trans = ws_primed_q & (ws_sync != ws_last_q);

    assign shift_nxt = {shift_q[NUM_BITS-2:0], sd_sync};
    assign count_inc = count_q + CNT_W'(1);

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            count_q      <= '0;
            chan_q       <= 1'b0;
            good_q       <= '0;
            ws_last_q    <= 1'b0;
            ws_primed_q  <= 1'b0;
            sample_data  <= '0;
            sample_chan  <= 1'b0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            chan_q       <= chan_d;
            good_q       <= good_d;
            ws_last_q    <= ws_last_d;
            ws_primed_q  <= ws_primed_d;
            sample_data  <= sample_data_d;
            sample_chan  <= sample_chan_d;
            sample_valid <= sample_valid_d;
            frame_err    <= frame_err_d;
            locked       <= locked_d;
        end
    end

    // Framing FSM: advances only on bit-clock rising edges
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        count_d        = count_q;
        chan_d         = chan_q;
        good_d         = good_q;
        ws_last_d      = ws_last_q;
        ws_primed_d    = ws_primed_q;
        sample_data_d  = sample_data;
        sample_chan_d  = sample_chan;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        locked_d       = locked;

        if (s_clk_pos) begin
            ws_last_d   = ws_sync;
            ws_primed_d = 1'b1;

            case (state_q)
                ST_IDLE: begin
                    // Partial slot after reset is dropped; wait for a slot boundary
                    if (ws_trans) begin
                        state_d = ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (ws_trans) begin
                        // Zero-length slot
                        frame_err_d = 1'b1;
                        good_d      = '0;
                        locked_d    = 1'b0;
                    end else begin
                        shift_d = {{(NUM_BITS-1){1'b0}}, sd_sync};
                        count_d = CNT_W'(1);
                        chan_d  = ws_sync;
                        state_d = ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (count_inc == CNT_FULL) begin
                        // Completing edge wins over a simultaneous WS change
                        shift_d        = shift_nxt;
                        count_d        = count_inc;
                        sample_data_d  = shift_nxt;
                        sample_chan_d  = chan_q;
                        sample_valid_d = 1'b1;
                        good_d         = good_q | (NUM_CHAN'(1) << chan_q);
                        locked_d       = &good_d;
                        state_d        = ws_trans ? ST_ARMED : ST_WAIT;
                    end else if (ws_trans) begin
                        // Slot ended early; this edge's bit belongs to the old slot
                        frame_err_d = 1'b1;
                        good_d      = '0;
                        locked_d    = 1'b0;
                        shift_d     = '0;
                        count_d     = '0;
                        state_d     = ST_ARMED;
                    end else begin
                        shift_d = shift_nxt;
                        count_d = count_inc;
                    end
                end

                ST_WAIT: begin
                    // Slot padding beyond NUM_BITS is ignored
                    if (ws_trans) begin
                        state_d = ST_ARMED;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: an I2S transmitter model drives WS/SD
// on the falling bit clock, expected words go into a scoreboard queue and are
// compared as sample_valid pulses appear.
`timescale 1ns/1ps

module tb_i2s_receiver;

    logic        clk;
    logic        rst;
    logic        s_clk;
    logic        ws_in;
    logic        sd_in;
    logic [23:0] sample_data;
    logic        sample_chan;
    logic        sample_valid;
    logic        frame_err;
    logic        locked;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_err    = 0;

    logic [24:0] exp_q[$];
    logic [24:0] mon_exp;

    // Transmitter state: last bit of a slot goes out with the next slot's WS
    logic pend_sd  = 1'b0;
    bit   pend_chk = 1'b0;
    bit   lat_chk  = 1'b0;
    logic cur_ws   = 1'b0;

    localparam int FRAMES = 100;

    i2s_receiver #(
        .NUM_BITS(24),
        .NUM_CHAN(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_clk       (s_clk),
        .word_select (ws_in),
        .serial_data (sd_in),
        .sample_data (sample_data),
        .sample_chan (sample_chan),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: pops one expected word per valid pulse
    always @(posedge clk) begin
        #1;
        if (frame_err === 1'b1) n_err++;
        if (sample_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid chan=%b data=%h (no word expected)",
                         sample_chan, sample_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({sample_chan, sample_data} !== mon_exp) begin
                    failures++;
                    $display("FAIL word chan=%b data=%h expected chan=%b data=%h",
                             sample_chan, sample_data, mon_exp[24], mon_exp[23:0]);
                end
            end
        end
    end

    // One bit cell: falling s_clk with new WS/SD, rising s_clk half later
    task automatic send_bit(input logic ws, input logic sd, input int half, input bit chk);
        @(negedge clk);
        s_clk = 1'b0;
        ws_in = ws;
        sd_in = sd;
        repeat (half) @(negedge clk);
        s_clk = 1'b1;
        if (chk) begin
            // Two sync flops + edge detect, then one registered cycle
            for (int k = 1; k <= 3; k++) begin
                @(posedge clk);
                #1;
                checks++;
                if (sample_valid !== (k == 3)) begin
                    failures++;
                    $display("FAIL latency_k%0d sample_valid=%b expected=%b",
                             k, sample_valid, (k == 3));
                end
            end
        end else begin
            repeat (half - 1) @(negedge clk);
        end
    endtask

    // One slot of len bits for channel ws; cap pushes the expected word
    task automatic send_slot(input logic ws, input logic [23:0] word, input int len,
                             input bit cap, input int half);
        logic b;
        if (cap) exp_q.push_back({ws, word});
        send_bit(ws, pend_sd, half, pend_chk);
        for (int i = 0; i < len - 1; i++) begin
            b = (i < 24) ? word[23-i] : 1'($urandom_range(0, 1));
            send_bit(ws, b, half, lat_chk && cap && (i == 23));
        end
        pend_sd  = (len - 1 < 24) ? word[24-len] : 1'b0;
        pend_chk = lat_chk && cap && (len == 24);
        cur_ws   = ws;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        s_clk = 1'b0;
        ws_in = 1'b0;
        sd_in = 1'b0;
        repeat (4) @(negedge clk);
        checks += 5;
        if (sample_data !== 24'h0)   begin failures++; $display("FAIL reset_data got=%h exp=0", sample_data); end
        if (sample_chan !== 1'b0)    begin failures++; $display("FAIL reset_chan got=%b exp=0", sample_chan); end
        if (sample_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
        if (frame_err !== 1'b0)      begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        if (locked !== 1'b0)         begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nominal();
        int e0;
        int v0;
        e0 = n_err;
        v0 = n_valid;
        send_slot(1'b1, 24'h000000, 12, 1'b0, 4);
        checks += 2;
        if (n_err !== e0) begin failures++; $display("FAIL nominal_partial_err got=%0d exp=%0d", n_err - e0, 0); end
        if (n_valid !== v0) begin failures++; $display("FAIL nominal_partial_valid got=%0d exp=%0d", n_valid - v0, 0); end
        send_slot(1'b0, 24'h123456, 32, 1'b1, 4);
        checks += 2;
        if (locked !== 1'b0) begin failures++; $display("FAIL nominal_locked_left got=%b exp=0", locked); end
        if (n_valid - v0 !== 1) begin failures++; $display("FAIL nominal_count_left got=%0d exp=1", n_valid - v0); end
        send_slot(1'b1, 24'hABCDEF, 32, 1'b1, 4);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL nominal_locked_right got=%b exp=1", locked); end
        send_slot(1'b0, 24'h123456, 32, 1'b1, 4);
        send_slot(1'b1, 24'hABCDEF, 32, 1'b1, 4);
        checks += 2;
        if (n_err !== e0) begin failures++; $display("FAIL nominal_err got=%0d exp=0", n_err - e0); end
        if (n_valid - v0 !== 4) begin failures++; $display("FAIL nominal_count got=%0d exp=4", n_valid - v0); end
    endtask

    task automatic test_exact_fit();
        int e0;
        int v0;
        e0 = n_err;
        v0 = n_valid;
        for (int f = 0; f < 3; f++) begin
            send_slot(1'b0, 24'h800001, 24, 1'b1, 4);
            send_slot(1'b1, 24'h7FFFFF, 24, 1'b1, 4);
        end
        checks += 3;
        if (n_err !== e0) begin failures++; $display("FAIL exact_err got=%0d exp=0", n_err - e0); end
        if (locked !== 1'b1) begin failures++; $display("FAIL exact_locked got=%b exp=1", locked); end
        // The final right word still waits for its deferred LSB
        if (n_valid - v0 !== 5) begin failures++; $display("FAIL exact_count got=%0d exp=5", n_valid - v0); end
    endtask

    task automatic test_short_slot();
        int e0;
        e0 = n_err;
        send_slot(1'b0, 24'h5A5A5A, 16, 1'b0, 4);
        send_slot(1'b1, 24'h13579B, 32, 1'b1, 4);
        checks += 2;
        if (n_err - e0 !== 1) begin failures++; $display("FAIL short_err got=%0d exp=1", n_err - e0); end
        if (locked !== 1'b0) begin failures++; $display("FAIL short_locked_drop got=%b exp=0", locked); end
        send_slot(1'b0, 24'h2468AC, 32, 1'b1, 4);
        checks += 2;
        if (locked !== 1'b1) begin failures++; $display("FAIL short_locked_back got=%b exp=1", locked); end
        if (n_err - e0 !== 1) begin failures++; $display("FAIL short_err_after got=%0d exp=1", n_err - e0); end
    endtask

    task automatic test_reset_mid_word();
        int e0;
        int v0;
        send_slot(1'b1, 24'hC0FFEE, 10, 1'b0, 4);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 5;
        if (sample_data !== 24'h0)  begin failures++; $display("FAIL midrst_data got=%h exp=0", sample_data); end
        if (sample_chan !== 1'b0)   begin failures++; $display("FAIL midrst_chan got=%b exp=0", sample_chan); end
        if (sample_valid !== 1'b0)  begin failures++; $display("FAIL midrst_valid got=%b exp=0", sample_valid); end
        if (frame_err !== 1'b0)     begin failures++; $display("FAIL midrst_err got=%b exp=0", frame_err); end
        if (locked !== 1'b0)        begin failures++; $display("FAIL midrst_locked got=%b exp=0", locked); end
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        pend_sd  = 1'b0;
        pend_chk = 1'b0;
        e0 = n_err;
        v0 = n_valid;
        send_slot(1'b1, 24'h3C3C3C, 15, 1'b0, 4);
        checks += 2;
        if (n_valid !== v0) begin failures++; $display("FAIL midrst_stale_valid got=%0d exp=0", n_valid - v0); end
        if (n_err !== e0) begin failures++; $display("FAIL midrst_err_after got=%0d exp=0", n_err - e0); end
        send_slot(1'b0, 24'h112233, 32, 1'b1, 4);
        checks += 2;
        if (locked !== 1'b0) begin failures++; $display("FAIL midrst_locked_one got=%b exp=0", locked); end
        if (n_valid - v0 !== 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", n_valid - v0); end
        send_slot(1'b1, 24'h445566, 32, 1'b1, 4);
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL midrst_locked_two got=%b exp=1", locked); end
    endtask

    task automatic test_latency();
        int e0;
        e0 = n_err;
        lat_chk = 1'b1;
        send_slot(1'b0, 24'hFEDCBA, 24, 1'b1, 4);
        send_slot(1'b1, 24'h000001, 24, 1'b1, 4);
        send_slot(1'b0, 24'h654321, 32, 1'b1, 4);
        send_slot(1'b1, 24'h800000, 32, 1'b1, 4);
        lat_chk = 1'b0;
        checks++;
        if (n_err !== e0) begin failures++; $display("FAIL latency_err got=%0d exp=0", n_err - e0); end
    endtask

    task automatic test_random();
        int e0;
        int v0;
        int n;
        e0 = n_err;
        v0 = n_valid;
        n  = 0;
        for (int f = 0; f < FRAMES; f++) begin
            for (int ch = 0; ch < 2; ch++) begin
                send_slot(1'(ch), 24'($urandom), $urandom_range(24, 32), 1'b1, 3);
                n++;
            end
        end
        // Deliver the pending last bit without a WS change
        send_bit(cur_ws, pend_sd, 3, 1'b0);
        repeat (10) @(negedge clk);
        checks += 4;
        if (n_valid - v0 !== n) begin failures++; $display("FAIL random_count got=%0d exp=%0d", n_valid - v0, n); end
        if (n_err !== e0) begin failures++; $display("FAIL random_err got=%0d exp=0", n_err - e0); end
        if (locked !== 1'b1) begin failures++; $display("FAIL random_locked got=%b exp=1", locked); end
        if (exp_q.size() !== 0) begin failures++; $display("FAIL random_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_exact_fit();
        test_short_slot();
        test_reset_mid_word();
        test_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
